alsu_result_fifo: RTL

ALSU_RESULT_FIFO -- requirements
Module: alsu_result_fifo

---
 rtl/alsu_result_fifo.sv | 97 +++++++++
 1 files changed

// File: rtl/alsu_result_fifo.sv
// First-word-fall-through result FIFO for the ALSU: buffers {out, parity, invalid}
// entries and keeps a saturating invalid-result tally and a sticky drop flag.
module alsu_result_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_valid,
    input  logic [2*WIDTH-1:0]       wr_out,
    input  logic                     wr_parity,
    input  logic                     wr_invalid,
    input  logic                     rd_ready,
    input  logic                     clear,
    output logic                     rd_valid,
    output logic [2*WIDTH-1:0]       rd_out,
    output logic                     rd_parity,
    output logic                     rd_invalid,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [7:0]               invalid_cnt,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = 2*WIDTH + 2;
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pop;
    logic          push;
    logic          drop;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign rd_valid = !empty;
    assign pop      = rd_valid && rd_ready;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign push     = wr_valid && (!full || pop);
    assign drop     = wr_valid && !push;

    assign {rd_out, rd_parity, rd_invalid} = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= {wr_out, wr_parity, wr_invalid};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Clear outranks any same-cycle increment or overflow set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            invalid_cnt <= '0;
            overflow    <= 1'b0;
        end else if (clear) begin
            invalid_cnt <= '0;
            overflow    <= 1'b0;
        end else begin
            if (push && wr_invalid && (invalid_cnt != 8'hFF)) begin
                invalid_cnt <= invalid_cnt + 8'd1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule
